uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single byte-wide TX path into the TX escape stage between NUM_REQ byte-stream requesters
//   (e.g. DMI TAP responses, STB0/STB1 trace streams). Grants whole frames, round-robin, never interleaving.
//   Emits one SELECT command byte (via the escape command path) whenever the frame owner changes, so the
//   host can demultiplex. Frames that stall inside their body are aborted after a timeout.
// PARAMETERS
//   NUM_REQ        2       number of requesters, 1..4
//   TIMEOUT_CYCLES 1024    max consecutive STREAM cycles with owner VALID low before abort, >=2
//   CMD_SELECT     8'h10   SELECT command base; COMMAND_O = CMD_SELECT | id (low 2 bits zero)
// PORTS
//   CLK_I            in   1          clock
//   RST_NI           in   1          async reset, active low
//   REQ_VALID_I      in   NUM_REQ    per-requester byte valid
//   REQ_READY_O      out  NUM_REQ    per-requester byte accepted (valid&ready = transfer)
//   REQ_DATA_I       in   8*NUM_REQ  byte of requester i at [8*i+:8]
//   REQ_LAST_I       in   NUM_REQ    byte is final byte of frame
//   TX_READY_I       in   1          escape stage can take a data or command byte this cycle
//   WRITE_O          out  1          data byte write strobe to escape stage
//   DATA_SEND_O      out  8          data byte
//   WRITE_COMMAND_O  out  1          command byte write strobe to escape stage
//   COMMAND_O        out  8          command byte
//   GRANT_O          out  NUM_REQ    one-hot current owner, 0 when none
//   TIMEOUT_O        out  1          one-cycle pulse on frame abort
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr pointer = NUM_REQ-1 (req 0 wins first); sel_valid=0.
//   FSM IDLE -> SELECT | STREAM; SELECT -> STREAM; STREAM -> IDLE.
//   IDLE: if any REQ_VALID_I, registered round-robin pick starting at ptr+1; owner/GRANT_O valid next cycle.
//     Next = SELECT if !sel_valid or owner != last_sel, else STREAM. No READY/WRITE in IDLE.
//   SELECT: WRITE_COMMAND_O = TX_READY_I, COMMAND_O = CMD_SELECT|owner (held while waiting).
//     On TX_READY_I: last_sel<=owner, sel_valid<=1, -> STREAM.
//   STREAM (combinational, zero latency): REQ_READY_O[owner] = TX_READY_I;
//     WRITE_O = REQ_VALID_I[owner] & TX_READY_I; DATA_SEND_O = owner byte. Other READY bits 0.
//     Transfer with REQ_LAST_I[owner]: ptr<=owner, GRANT_O<=0, -> IDLE.
//   Arbitration gap: min 1 IDLE cycle between frames even if another requester already valid.
//   Timeout counter: cleared on entering STREAM and on each cycle owner VALID=1; increments otherwise;
//     at TIMEOUT_CYCLES-1 with VALID still 0: TIMEOUT_O=1, ptr<=owner, sel_valid<=0, -> IDLE.
//     VALID rising in the expiry cycle wins (no abort). Counter not running in IDLE/SELECT.
//   WRITE_O and WRITE_COMMAND_O never high in same cycle; neither high when TX_READY_I=0.
//   Requester VALID dropped in IDLE before grant: ignored, no grant. VALID for non-owner: held, READY 0.
//   NUM_REQ=1: arbitration trivial; SELECT still emitted once after reset and after every timeout.
//   Reset mid-frame: immediate async return to reset state; partial frame is lost, next grant re-sends SELECT.
//   DATA_SEND_O/COMMAND_O: don't-care when strobe low, but driven 0 in IDLE.
// STRUCTURE
//   uart_pkg additions: CMD_SELECT default, typedef enum logic [1:0] {ARB_IDLE, ARB_SELECT, ARB_STREAM}
//     arb_state_e, localparam REQ_ID_W = 2.
//   Sub-module rr_arbiter #(N): pointer in, request vector in, one-hot grant + index out (combinational);
//     FSM, timeout counter, sel tracking stay here.
// TESTING
//   T1 after reset, req0 frame 3 bytes 0xA1,0xA2,0xA3(LAST), TX_READY=1 -> CMD 0x10, then 3 writes, GRANT_O=0 after.
//   T2 req0 and req1 valid together -> req0 frame first, 1 IDLE cycle, CMD 0x11, req1 frame; next tie -> req0 again.
//   T3 req1 two back-to-back frames, req0 idle -> CMD 0x11 only before first frame, none before second.
//   T4 TX_READY toggling 1/0 during SELECT and STREAM -> no strobe when 0, bytes in order, none duplicated.
//   T5 TIMEOUT_CYCLES=8, req0 stalls after 1 byte -> TIMEOUT_O pulse 8 cycles later, IDLE, next req0 frame re-sends 0x10.
//   T6 RST_NI low mid-frame, release, req1 valid -> all outputs 0 during reset, CMD 0x11 then req1 data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX path: SELECT command base, arbiter FSM encoding
// and the width of a requester id as carried in a SELECT command byte.
package uart_pkg;

    localparam logic [7:0] CMD_SELECT_DEFAULT = 8'h10;

    localparam int REQ_ID_W = 2;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SELECT,
        ARB_STREAM
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr_i wins,
// wrapping around so that ptr_i itself has the lowest priority.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [REQ_ID_W-1:0] ptr_i,
    input  logic [N-1:0]        req_i,
    output logic [N-1:0]        gnt_o,
    output logic [REQ_ID_W-1:0] idx_o,
    output logic                any_o
);

    logic found;

    // NOTE: every signal gets a default at the top of the block so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i > int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = REQ_ID_W'(i);
            end
        end
        // Wrap-around pass: indices at or below the pointer.
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (i <= int'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = REQ_ID_W'(i);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-level round-robin arbiter in front of the TX escape stage. Emits a SELECT command
// whenever the frame owner changes and aborts frames whose owner stalls for too long.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NUM_REQ        = 2,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] CMD_SELECT     = CMD_SELECT_DEFAULT
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic [NUM_REQ-1:0]   REQ_VALID_I,
    output logic [NUM_REQ-1:0]   REQ_READY_O,
    input  logic [8*NUM_REQ-1:0] REQ_DATA_I,
    input  logic [NUM_REQ-1:0]   REQ_LAST_I,
    input  logic                 TX_READY_I,
    output logic                 WRITE_O,
    output logic [7:0]           DATA_SEND_O,
    output logic                 WRITE_COMMAND_O,
    output logic [7:0]           COMMAND_O,
    output logic [NUM_REQ-1:0]   GRANT_O,
    output logic                 TIMEOUT_O
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e          state_q, state_d;
    logic [REQ_ID_W-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [REQ_ID_W-1:0] ptr_q, ptr_d;
    logic [REQ_ID_W-1:0] last_sel_q, last_sel_d;
    logic                sel_valid_q, sel_valid_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [REQ_ID_W-1:0] pick_idx;
    logic                pick_any;

    logic                owner_valid;
    logic                owner_last;
    logic [7:0]          owner_data;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .ptr_i (ptr_q),
        .req_i (REQ_VALID_I),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // The one-hot grant doubles as the owner mux select.
    always_comb begin
        owner_valid = |(REQ_VALID_I & grant_q);
        owner_last  = |(REQ_LAST_I & grant_q);
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = REQ_DATA_I[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        grant_d         = grant_q;
        ptr_d           = ptr_q;
        last_sel_d      = last_sel_q;
        sel_valid_d     = sel_valid_q;
        tmo_cnt_d       = tmo_cnt_q;
        REQ_READY_O     = '0;
        WRITE_O         = 1'b0;
        DATA_SEND_O     = '0;
        WRITE_COMMAND_O = 1'b0;
        COMMAND_O       = '0;
        TIMEOUT_O       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                tmo_cnt_d = '0;
                if (pick_any) begin
                    owner_d = pick_idx;
                    grant_d = pick_gnt;
                    state_d = (!sel_valid_q || (pick_idx != last_sel_q)) ? ARB_SELECT : ARB_STREAM;
                end
            end

            ARB_SELECT: begin
                WRITE_COMMAND_O = TX_READY_I;
                COMMAND_O       = CMD_SELECT | 8'(owner_q);
                if (TX_READY_I) begin
                    last_sel_d  = owner_q;
                    sel_valid_d = 1'b1;
                    state_d     = ARB_STREAM;
                end
            end

            ARB_STREAM: begin
                REQ_READY_O = TX_READY_I ? grant_q : '0;
                WRITE_O     = owner_valid & TX_READY_I;
                DATA_SEND_O = owner_data;
                if (owner_valid) begin
                    tmo_cnt_d = '0;
                    if (TX_READY_I && owner_last) begin
                        ptr_d   = owner_q;
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (tmo_cnt_q == CNT_LAST) begin
                    // Owner went silent mid-frame: the host must see a fresh SELECT next time.
                    TIMEOUT_O   = 1'b1;
                    ptr_d       = owner_q;
                    sel_valid_d = 1'b0;
                    grant_d     = '0;
                    state_d     = ARB_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign GRANT_O = grant_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            grant_q     <= '0;
            ptr_q       <= REQ_ID_W'(NUM_REQ - 1);
            last_sel_q  <= '0;
            sel_valid_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            last_sel_q  <= last_sel_d;
            sel_valid_q <= sel_valid_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte drivers, a strobe scoreboard fed by the
// stimulus, a frame table and hand-written sequences for ordering, stalls and reset.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 2;
    localparam int TMO     = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic       is_cmd;
        logic [7:0] val;
        logic [1:0] grant;
        int         gap;
    } exp_t;

    typedef struct {
        int         id;
        int         len;
        logic [7:0] first;
        bit         sel;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_data;
    logic [1:0]   req_last;
    logic         tx_ready;
    logic         write;
    logic [7:0]   data_send;
    logic         write_cmd;
    logic [7:0]   command;
    logic [1:0]   grant;
    logic         timeout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_strobe_cyc = 0;
    int last_data_cyc = 0;
    int data_strobes = 0;
    int tmo_count = 0;
    int timeout_cyc = 0;
    bit mon_ignore = 1'b0;
    bit toggle_ready = 1'b0;
    logic [1:0] hs = '0;

    beat_t drv0[$];
    beat_t drv1[$];
    exp_t  sb[$];
    vec_t  vecs[5];

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TMO),
        .CMD_SELECT     (8'h10)
    ) dut (
        .CLK_I           (clk),
        .RST_NI          (rst_n),
        .REQ_VALID_I     (req_valid),
        .REQ_READY_O     (req_ready),
        .REQ_DATA_I      (req_data),
        .REQ_LAST_I      (req_last),
        .TX_READY_I      (tx_ready),
        .WRITE_O         (write),
        .DATA_SEND_O     (data_send),
        .WRITE_COMMAND_O (write_cmd),
        .COMMAND_O       (command),
        .GRANT_O         (grant),
        .TIMEOUT_O       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_frame(input int id, input int len, input logic [7:0] first,
                              input bit sel, input int gap, input bit track, input bit close);
        exp_t       e;
        beat_t      b;
        logic [1:0] oh;
        oh = 2'(1 << id);
        if (track && sel) begin
            e.is_cmd = 1'b1;
            e.val    = 8'h10 | 8'(id);
            e.grant  = oh;
            e.gap    = gap;
            sb.push_back(e);
        end
        for (int k = 0; k < len; k++) begin
            e.is_cmd = 1'b0;
            e.val    = first + 8'(k);
            e.grant  = oh;
            e.gap    = (!sel && k == 0) ? gap : 0;
            if (track) sb.push_back(e);
            b.data = e.val;
            b.last = close && (k == len - 1);
            if (id == 0) drv0.push_back(b);
            else         drv1.push_back(b);
        end
    endtask

    task automatic wait_sb();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || drv0.size() != 0 || drv1.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("scoreboard_drained", 32'(sb.size()), 0);
        @(negedge clk);
        #1;
        check("grant_released", {30'b0, grant}, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Requester drivers: pop a beat on the edge after a handshake was seen, then present the next.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs[0] && drv0.size() > 0) void'(drv0.pop_front());
            if (hs[1] && drv1.size() > 0) void'(drv1.pop_front());
            if (drv0.size() > 0) begin
                req_valid[0]   = 1'b1;
                req_data[7:0]  = drv0[0].data;
                req_last[0]    = drv0[0].last;
            end else begin
                req_valid[0]   = 1'b0;
                req_data[7:0]  = '0;
                req_last[0]    = 1'b0;
            end
            if (drv1.size() > 0) begin
                req_valid[1]   = 1'b1;
                req_data[15:8] = drv1[0].data;
                req_last[1]    = drv1[0].last;
            end else begin
                req_valid[1]   = 1'b0;
                req_data[15:8] = '0;
                req_last[1]    = 1'b0;
            end
            if (toggle_ready) tx_ready = ~tx_ready;
        end
    end

    // Output monitor and scoreboard consumer, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (rst_n) begin
                if (!tx_ready) check("no_strobe_when_tx_busy", {30'b0, write, write_cmd}, 0);
                if (write || write_cmd) begin
                    check("strobes_exclusive", {31'b0, write & write_cmd}, 0);
                    if (!mon_ignore) begin
                        check("scoreboard_has_entry", {31'b0, sb.size() > 0}, 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("strobe_kind", {31'b0, write_cmd}, {31'b0, e.is_cmd});
                            check("byte_value", {24'b0, write_cmd ? command : data_send}, {24'b0, e.val});
                            check("grant_owner", {30'b0, grant}, {30'b0, e.grant});
                            check("ready_owner_only", {30'b0, req_ready}, e.is_cmd ? 32'd0 : {30'b0, e.grant});
                            if (e.gap != 0) check("strobe_gap", cyc - last_strobe_cyc, e.gap);
                        end
                    end
                    last_strobe_cyc = cyc;
                    if (write) begin
                        last_data_cyc = cyc;
                        data_strobes++;
                    end
                end
                if (grant == '0) check("idle_outputs_quiet", {14'b0, data_send, command, req_ready}, 0);
                if (timeout) begin
                    tmo_count++;
                    timeout_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        int n;
        int tmo_before;
        int base;

        vecs[0] = '{id: 0, len: 3, first: 8'hA1, sel: 1'b1};
        vecs[1] = '{id: 1, len: 2, first: 8'h30, sel: 1'b1};
        vecs[2] = '{id: 1, len: 1, first: 8'h38, sel: 1'b0};
        vecs[3] = '{id: 0, len: 4, first: 8'h50, sel: 1'b1};
        vecs[4] = '{id: 0, len: 2, first: 8'h58, sel: 1'b0};

        rst_n    = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {9'b0, req_ready, write, data_send, write_cmd, command, grant, timeout}, 0);
        rst_n = 1'b1;

        // Single frames one at a time; the first is the post-reset req0 frame.
        for (int v = 0; v < 5; v++) begin
            push_frame(vecs[v].id, vecs[v].len, vecs[v].first, vecs[v].sel, 0, 1'b1, 1'b1);
            wait_idle();
        end

        // Back-to-back frames from req1: one SELECT only, then the arbitration gap.
        push_frame(1, 3, 8'h60, 1'b1, 0, 1'b1, 1'b1);
        push_frame(1, 2, 8'h68, 1'b0, 2, 1'b1, 1'b1);
        wait_idle();

        // Simultaneous requests twice: req0 wins both ties, req1 follows after one idle cycle.
        push_frame(0, 2, 8'h70, 1'b1, 0, 1'b1, 1'b1);
        push_frame(1, 2, 8'h78, 1'b1, 2, 1'b1, 1'b1);
        wait_idle();
        push_frame(0, 1, 8'h7C, 1'b1, 0, 1'b1, 1'b1);
        push_frame(1, 1, 8'h7E, 1'b1, 2, 1'b1, 1'b1);
        wait_idle();

        // TX_READY alternating during SELECT and STREAM.
        toggle_ready = 1'b1;
        push_frame(0, 4, 8'h90, 1'b1, 0, 1'b1, 1'b1);
        push_frame(1, 3, 8'h98, 1'b1, 0, 1'b1, 1'b1);
        wait_idle();
        toggle_ready = 1'b0;
        tx_ready     = 1'b1;
        @(negedge clk);
        #1;

        // VALID returning in the expiry cycle wins: no abort, byte lands 8 cycles on.
        tmo_before = tmo_count;
        push_frame(0, 1, 8'hB0, 1'b1, 0, 1'b1, 1'b0);
        wait_sb();
        c = last_data_cyc;
        n = 0;
        while (cyc < c + TMO - 1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        push_frame(0, 1, 8'hB1, 1'b0, TMO, 1'b1, 1'b1);
        wait_idle();
        check("no_abort_when_valid_returns", tmo_count, tmo_before);

        // Stall after one byte: abort 8 cycles after the last transfer, then SELECT is re-sent.
        push_frame(0, 1, 8'hC0, 1'b0, 0, 1'b1, 1'b0);
        wait_sb();
        c = last_data_cyc;
        n = 0;
        while (tmo_count == tmo_before && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("timeout_pulse_seen", tmo_count, tmo_before + 1);
        check("timeout_latency", timeout_cyc - c, TMO);
        @(negedge clk);
        #1;
        check("timeout_one_cycle", {31'b0, timeout}, 0);
        check("grant_clear_after_abort", {30'b0, grant}, 0);
        push_frame(0, 2, 8'hD0, 1'b1, 0, 1'b1, 1'b1);
        wait_idle();

        // Reset in the middle of a req0 frame, then a fresh req1 frame.
        mon_ignore = 1'b1;
        base       = data_strobes;
        push_frame(0, 6, 8'hE0, 1'b0, 0, 1'b0, 1'b1);
        n = 0;
        while (data_strobes < base + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("partial_frame_started", {31'b0, data_strobes >= base + 2}, 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {9'b0, req_ready, write, data_send, write_cmd, command, grant, timeout}, 0);
        sb.delete();
        drv0.delete();
        drv1.delete();
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold_outputs",
              {9'b0, req_ready, write, data_send, write_cmd, command, grant, timeout}, 0);
        rst_n      = 1'b1;
        mon_ignore = 1'b0;
        push_frame(1, 2, 8'hF0, 1'b1, 0, 1'b1, 1'b1);
        wait_idle();

        check("timeout_total", tmo_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
